rv_multicycle_controller: RTL
=============================

Name: rv_multicycle_controller

Overview:
- Multi-cycle control FSM for the RV32IM core.
- Sequences instruction fetch, decode, execute, memory and writeback over a shared memory port and the shared ALU.
- Drives the immediate generator's select, the register-file write enable, PC update and the multiply/divide unit (MDU) start handshake.
- Sits between the instruction register and the datapath muxes; one instruction in flight at a time.

Parameters:
- MDU_TIMEOUT, 64, max cycles waited in MDU_WAIT for mdu_done before trapping (range 1..255).

Ports:
- clk  input  1  core clock
- rst  input  1  synchronous active-high reset
- ins  input  32  instruction register contents (valid from DECODE onward)
- mem_ready  input  1  memory port accepts/completes current request this cycle
- br_taken  input  1  branch comparator result, valid in EXEC
- mdu_done  input  1  MDU result valid pulse
- ir_write  output  1  load instruction register
- pc_write  output  1  update PC
- pc_sel  output  2  00 PC+4, 01 PC+imm, 10 ALU result with bit0 cleared (JALR)
- mem_req  output  1  memory request
- mem_we  output  1  store when mem_req=1
- mem_addr_sel  output  1  0 PC, 1 ALU result
- imm_sel  output  3  000 I, 001 S, 010 B, 011 J, 100 U
- alu_src_a  output  2  00 rs1, 01 PC, 10 zero
- alu_src_b  output  1  0 rs2, 1 immediate
- reg_write  output  1  register-file write enable
- wb_sel  output  2  00 ALU, 01 memory data, 10 PC+4, 11 MDU result
- mdu_start  output  1  one-cycle MDU launch pulse
- retire  output  1  one-cycle pulse when an instruction completes
- illegal  output  1  sticky trap flag

Behaviour:
- Clocking and reset: single clock. Reset is synchronous, active-high; on the next edge the state becomes FETCH and the MDU counter clears.
- Output reset values: all outputs 0, including imm_sel=000 and illegal=0.
- Reset mid-operation aborts any pending mem_req or MDU wait. No store is issued after the reset edge.
- States: FETCH, DECODE, EXEC, MEM, WB, MDU_WAIT, TRAP. Outputs are decoded combinationally from state and ins.
- FETCH:
  - mem_req=1, mem_addr_sel=0.
  - Hold until mem_ready=1; zero-wait is allowed (ready in the same cycle as req).
  - On ready: ir_write=1, then go to DECODE.
- DECODE:
  - Classify ins[6:0]; imm_sel becomes valid and stays stable through WB.
  - Legal classes are LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP-IMM and OP (funct7 0000000/0100000, or 0000001 for M).
  - Anything else goes to TRAP.
- EXEC:
  - OP/OP-IMM: alu_src_b=0/1 → WB.
  - LOAD/STORE: alu_src_b=1 → MEM.
  - LUI: alu_src_a=10, alu_src_b=1 → WB.
  - AUIPC: alu_src_a=01, alu_src_b=1 → WB.
  - BRANCH: pc_write=1, pc_sel = br_taken ? 01 : 00, retire=1 → FETCH.
  - JAL/JALR: → WB.
  - M-extension: mdu_start=1 for exactly one cycle → MDU_WAIT.
- MEM:
  - mem_req=1, mem_addr_sel=1, mem_we=1 for STORE.
  - Hold until mem_ready.
  - LOAD → WB.
  - STORE: pc_write=1, pc_sel=00, retire=1 → FETCH.
- WB:
  - reg_write=1 and pc_write=1; retire=1 → FETCH.
  - wb_sel per class: ALU 00, LOAD 01, JAL/JALR 10, M 11.
  - pc_sel: JAL 01, JALR 10, else 00.
  - rd=x0 still asserts reg_write; the register file ignores it.
- MDU_WAIT:
  - 8-bit counter increments each cycle.
  - mdu_done is sampled only in this state; done in the mdu_start cycle is ignored.
  - done → WB.
  - Counter reaching MDU_TIMEOUT without done → TRAP.
- TRAP: illegal=1; no requests, no writes, no retire. Exit only via rst.
- Latency with zero-wait memory: ALU/LUI/AUIPC/JAL/JALR 4 cycles; load 5; store 4; branch 3; M 4 + MDU latency.

Decomposition:
- Shared package rv_ctrl_pkg holds:
  - the state enum;
  - imm_sel, pc_sel, wb_sel and alu_src_a encodings;
  - opcode constants;
  - the instruction-class enum.
- One combinational sub-module, rv_main_decoder: ins → class, imm_sel, illegal.

Test Plan:
- ADDI x1,x0,5 (0x00500093), mem_ready always 1 → reg_write pulse in cycle 4, wb_sel=00, imm_sel=000, pc_sel=00, retire once.
- SW (0x0020A223), mem_ready delayed 3 cycles in MEM → mem_we=1 held 4 cycles, no reg_write, retire when ready.
- BEQ (0x00000463) with br_taken=1, then br_taken=0 → pc_sel=01 then 00; imm_sel=010; 3-cycle instruction.
- MUL (0x022081B3) with mdu_done after 10 cycles → single mdu_start pulse, WB wb_sel=11. Repeat with no done and MDU_TIMEOUT=64 → illegal=1 after 64 wait cycles.
- Opcode 0x7F → TRAP, illegal sticky; assert rst during a pending FETCH mem_req → mem_req=0 and state FETCH the next cycle.

Source files
------------

// File: rtl/rv_ctrl_pkg.sv
// Shared types and encodings for the RV32IM multi-cycle controller and its decoder.
package rv_ctrl_pkg;

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_MDU_WAIT, S_TRAP
  } state_t;

  typedef enum logic [3:0] {
    C_LUI, C_AUIPC, C_JAL, C_JALR, C_BRANCH, C_LOAD, C_STORE,
    C_OPIMM, C_OP, C_MDU, C_ILL
  } cls_t;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  localparam logic [1:0] PC_PLUS4 = 2'b00;
  localparam logic [1:0] PC_IMM   = 2'b01;
  localparam logic [1:0] PC_ALU   = 2'b10;

  localparam logic [1:0] WB_ALU = 2'b00;
  localparam logic [1:0] WB_MEM = 2'b01;
  localparam logic [1:0] WB_PC4 = 2'b10;
  localparam logic [1:0] WB_MDU = 2'b11;

  localparam logic [1:0] SRC_A_RS1  = 2'b00;
  localparam logic [1:0] SRC_A_PC   = 2'b01;
  localparam logic [1:0] SRC_A_ZERO = 2'b10;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

endpackage

// File: rtl/rv_main_decoder.sv
// Combinational main decoder: instruction class, immediate format and illegal flag.
module rv_main_decoder
  import rv_ctrl_pkg::*;
(
  input  logic [31:0] i_ins,
  output cls_t        o_cls,
  output logic [2:0]  o_imm_sel,
  output logic        o_illegal
);

  logic [6:0] w_opc;
  logic [6:0] w_f7;
  logic       w_unused;

  assign w_opc    = i_ins[6:0];
  assign w_f7     = i_ins[31:25];
  assign w_unused = ^i_ins[24:7];

  always_comb begin
    o_cls     = C_ILL;
    o_imm_sel = IMM_I;
    case (w_opc)
      OPC_LUI:    begin o_cls = C_LUI;    o_imm_sel = IMM_U; end
      OPC_AUIPC:  begin o_cls = C_AUIPC;  o_imm_sel = IMM_U; end
      OPC_JAL:    begin o_cls = C_JAL;    o_imm_sel = IMM_J; end
      OPC_JALR:   o_cls = C_JALR;
      OPC_BRANCH: begin o_cls = C_BRANCH; o_imm_sel = IMM_B; end
      OPC_LOAD:   o_cls = C_LOAD;
      OPC_STORE:  begin o_cls = C_STORE;  o_imm_sel = IMM_S; end
      OPC_OPIMM:  o_cls = C_OPIMM;
      OPC_OP: begin
        if (w_f7 == 7'b0000000 || w_f7 == 7'b0100000) o_cls = C_OP;
        else if (w_f7 == 7'b0000001)                  o_cls = C_MDU;
      end
      default: o_cls = C_ILL;
    endcase
    o_illegal = (o_cls == C_ILL);
  end

endmodule

// File: rtl/rv_multicycle_controller.sv
// Multi-cycle control FSM for RV32IM: one instruction in flight, outputs decoded from state and ins.
module rv_multicycle_controller
  import rv_ctrl_pkg::*;
#(
  parameter int MDU_TIMEOUT = 64
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [31:0] i_ins,
  input  logic        i_mem_ready,
  input  logic        i_br_taken,
  input  logic        i_mdu_done,
  output logic        o_ir_write,
  output logic        o_pc_write,
  output logic [1:0]  o_pc_sel,
  output logic        o_mem_req,
  output logic        o_mem_we,
  output logic        o_mem_addr_sel,
  output logic [2:0]  o_imm_sel,
  output logic [1:0]  o_alu_src_a,
  output logic        o_alu_src_b,
  output logic        o_reg_write,
  output logic [1:0]  o_wb_sel,
  output logic        o_mdu_start,
  output logic        o_retire,
  output logic        o_illegal
);

  state_t     r_state;
  logic [7:0] r_mdu_cnt;
  cls_t       w_cls;
  logic [2:0] w_imm_sel;
  logic       w_dec_ill;
  logic [7:0] w_cnt_nxt;

  rv_main_decoder u_dec (
    .i_ins     (i_ins),
    .o_cls     (w_cls),
    .o_imm_sel (w_imm_sel),
    .o_illegal (w_dec_ill)
  );

  assign w_cnt_nxt = r_mdu_cnt + 8'd1;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= S_FETCH;
      r_mdu_cnt <= '0;
    end else begin
      case (r_state)
        S_FETCH:  if (i_mem_ready) r_state <= S_DECODE;
        S_DECODE: r_state <= w_dec_ill ? S_TRAP : S_EXEC;
        S_EXEC: begin
          case (w_cls)
            C_LOAD, C_STORE: r_state <= S_MEM;
            C_BRANCH:        r_state <= S_FETCH;
            C_MDU: begin
              r_state   <= S_MDU_WAIT;
              r_mdu_cnt <= '0;
            end
            default:         r_state <= S_WB;
          endcase
        end
        S_MEM:    if (i_mem_ready) r_state <= (w_cls == C_STORE) ? S_FETCH : S_WB;
        S_WB:     r_state <= S_FETCH;
        S_MDU_WAIT: begin
          // done wins over a timeout landing in the same cycle
          if (i_mdu_done) r_state <= S_WB;
          else begin
            r_mdu_cnt <= w_cnt_nxt;
            if (w_cnt_nxt == 8'(MDU_TIMEOUT)) r_state <= S_TRAP;
          end
        end
        S_TRAP:   r_state <= S_TRAP;
        default:  r_state <= S_FETCH;
      endcase
    end
  end

  always_comb begin
    o_ir_write     = 1'b0;
    o_pc_write     = 1'b0;
    o_pc_sel       = PC_PLUS4;
    o_mem_req      = 1'b0;
    o_mem_we       = 1'b0;
    o_mem_addr_sel = 1'b0;
    o_imm_sel      = IMM_I;
    o_alu_src_a    = SRC_A_RS1;
    o_alu_src_b    = 1'b0;
    o_reg_write    = 1'b0;
    o_wb_sel       = WB_ALU;
    o_mdu_start    = 1'b0;
    o_retire       = 1'b0;
    o_illegal      = 1'b0;
    // outputs held at zero while reset is asserted so nothing is issued under reset
    if (!i_rst) begin
      if (r_state != S_FETCH && r_state != S_TRAP) o_imm_sel = w_imm_sel;
      // ALU operands stay valid past EXEC so MEM addressing and JALR targets see them
      if (r_state == S_EXEC || r_state == S_MEM || r_state == S_WB || r_state == S_MDU_WAIT) begin
        case (w_cls)
          C_OPIMM, C_LOAD, C_STORE, C_JALR: o_alu_src_b = 1'b1;
          C_LUI:          begin o_alu_src_a = SRC_A_ZERO; o_alu_src_b = 1'b1; end
          C_AUIPC, C_JAL: begin o_alu_src_a = SRC_A_PC;   o_alu_src_b = 1'b1; end
          default: ;
        endcase
      end
      case (r_state)
        S_FETCH: begin
          o_mem_req  = 1'b1;
          o_ir_write = i_mem_ready;
        end
        S_EXEC: begin
          if (w_cls == C_BRANCH) begin
            o_pc_write = 1'b1;
            o_pc_sel   = i_br_taken ? PC_IMM : PC_PLUS4;
            o_retire   = 1'b1;
          end
          o_mdu_start = (w_cls == C_MDU);
        end
        S_MEM: begin
          o_mem_req      = 1'b1;
          o_mem_addr_sel = 1'b1;
          o_mem_we       = (w_cls == C_STORE);
          if (w_cls == C_STORE && i_mem_ready) begin
            o_pc_write = 1'b1;
            o_retire   = 1'b1;
          end
        end
        S_WB: begin
          o_reg_write = 1'b1;
          o_pc_write  = 1'b1;
          o_retire    = 1'b1;
          case (w_cls)
            C_LOAD:        o_wb_sel = WB_MEM;
            C_JAL, C_JALR: o_wb_sel = WB_PC4;
            C_MDU:         o_wb_sel = WB_MDU;
            default:       o_wb_sel = WB_ALU;
          endcase
          if (w_cls == C_JAL)       o_pc_sel = PC_IMM;
          else if (w_cls == C_JALR) o_pc_sel = PC_ALU;
        end
        S_TRAP:  o_illegal = 1'b1;
        default: ;
      endcase
    end
  end

endmodule
